rf_bank_arbiter: RTL

Schedules register-file bank accesses for the operand collector. It queues operand read requests (one or two operands per instruction, tagged with the destination collector unit) per bank. Each cycle it issues at most one access per bank and gives CDB write-back priority over reads. It returns each read's collector-unit tag one cycle later, aligned with the bank read data. It sits between the parallel-control dispatch stage and the four RF banks, and replaces the single-port sequencing in the RF controller.

---
 rtl/rf_arb_pkg.sv | 48 ++++
 rtl/rf_bank_arbiter_if.sv | 44 ++++
 rtl/rf_bank_queue.sv | 66 ++++++
 rtl/rf_bank_arbiter.sv | 98 +++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
`default_nettype none
// ============================================================
// Module : rf_arb_pkg
// Shared widths, bank queue entry type and per-bank bus packing.
// Rev    : 1.0
// ============================================================
package rf_arb_pkg;

  localparam int NBANK  = 4;
  localparam int ROW_W  = 3;
  localparam int OCID_W = 2;
  localparam int BANK_W = $clog2(NBANK);

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [OCID_W-1:0] ocid;
    logic              opsel;
  } rq_entry_t;

  typedef logic [ROW_W-1:0]  row_arr_t  [NBANK];
  typedef logic [OCID_W-1:0] ocid_arr_t [NBANK];

  function automatic logic [NBANK*ROW_W-1:0] pack_rows(input row_arr_t rows);
    logic [NBANK*ROW_W-1:0] packed_bus;
    packed_bus = '0;
    for (int n = 0; n < NBANK; n++) packed_bus[n*ROW_W +: ROW_W] = rows[n];
    return packed_bus;
  endfunction

  function automatic logic [NBANK*OCID_W-1:0] pack_ocids(input ocid_arr_t ocids);
    logic [NBANK*OCID_W-1:0] packed_bus;
    packed_bus = '0;
    for (int n = 0; n < NBANK; n++) packed_bus[n*OCID_W +: OCID_W] = ocids[n];
    return packed_bus;
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input logic [NBANK*ROW_W-1:0] packed_bus,
                                              input int n);
    return packed_bus[n*ROW_W +: ROW_W];
  endfunction

  function automatic logic [OCID_W-1:0] ocid_of(input logic [NBANK*OCID_W-1:0] packed_bus,
                                                input int n);
    return packed_bus[n*OCID_W +: OCID_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_bank_arbiter_if.sv
`default_nettype none
// ============================================================
// Module : rf_bank_arbiter_if
// Dispatch request, CDB write-back, bank strobes and tag return.
// Rev    : 1.0
// ============================================================
interface rf_bank_arbiter_if;
  import rf_arb_pkg::*;

  logic                    req_valid;
  logic                    req_ready;
  logic [OCID_W-1:0]       req_ocid;
  logic                    req_two_op;
  logic [ROW_W-1:0]        req_row_a;
  logic [BANK_W-1:0]       req_bank_a;
  logic [ROW_W-1:0]        req_row_b;
  logic [BANK_W-1:0]       req_bank_b;
  logic                    wb_en;
  logic [BANK_W-1:0]       wb_bank;
  logic [ROW_W-1:0]        wb_row;
  logic [NBANK-1:0]        bank_rd_en;
  logic [NBANK*ROW_W-1:0]  bank_rd_row;
  logic [NBANK-1:0]        bank_wr_en;
  logic [NBANK*ROW_W-1:0]  bank_wr_row;
  logic [NBANK-1:0]        bk_vld;
  logic [NBANK*OCID_W-1:0] bk_ocid;
  logic [NBANK-1:0]        bk_opsel;

  modport master (
    output req_valid, req_ocid, req_two_op, req_row_a, req_bank_a, req_row_b, req_bank_b,
    output wb_en, wb_bank, wb_row,
    input  req_ready, bank_rd_en, bank_rd_row, bank_wr_en, bank_wr_row,
    input  bk_vld, bk_ocid, bk_opsel
  );

  modport slave (
    input  req_valid, req_ocid, req_two_op, req_row_a, req_bank_a, req_row_b, req_bank_b,
    input  wb_en, wb_bank, wb_row,
    output req_ready, bank_rd_en, bank_rd_row, bank_wr_en, bank_wr_row,
    output bk_vld, bk_ocid, bk_opsel
  );

endinterface
`default_nettype wire

// File: rtl/rf_bank_queue.sv
`default_nettype none
// ============================================================
// Module : rf_bank_queue
// Single-bank request FIFO accepting up to two pushes per cycle.
// Rev    : 1.0
// ============================================================
module rf_bank_queue
  import rf_arb_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int CNT_W = $clog2(QDEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push0_i,
  input  rq_entry_t        push0_data_i,
  input  logic             push1_i,
  input  rq_entry_t        push1_data_i,
  input  logic             pop_i,
  output rq_entry_t        head_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] free_o
);

  localparam int PTR_W = $clog2(QDEPTH);

  rq_entry_t        mem_q [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] w_wr_idx1;
  logic             w_pop;

  assign w_pop     = pop_i && (count_q != '0);
  // The second push lands behind the first so a same-bank pair stays ordered.
  assign w_wr_idx1 = wr_ptr_q + PTR_W'(push0_i);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(w_pop);
    count_d  = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push0_i) mem_q[wr_ptr_q]  <= push0_data_i;
    if (push1_i) mem_q[w_wr_idx1] <= push1_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign free_o  = CNT_W'(QDEPTH) - count_q;

endmodule
`default_nettype wire

// File: rtl/rf_bank_arbiter.sv
`default_nettype none
// ============================================================
// Module : rf_bank_arbiter
// Per-bank operand read queues with write-back priority and tag return.
// Rev    : 1.0
// ============================================================
module rf_bank_arbiter
  import rf_arb_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  rf_bank_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(QDEPTH + 1);

  rq_entry_t        w_entry_a, w_entry_b;
  logic             w_ready, w_accept;
  logic [NBANK-1:0] w_fits, w_rd_en, w_wr_en;
  row_arr_t         w_rd_row, w_wr_row;
  rq_entry_t        w_head [NBANK];

  logic [NBANK-1:0] bk_vld_q, bk_vld_d;
  logic [NBANK-1:0] bk_opsel_q, bk_opsel_d;
  ocid_arr_t        bk_ocid_q, bk_ocid_d;

  assign w_entry_a = '{row: bus.req_row_a, ocid: bus.req_ocid, opsel: 1'b0};
  assign w_entry_b = '{row: bus.req_row_b, ocid: bus.req_ocid, opsel: 1'b1};

  // Free space is taken before this cycle's pops so readiness never depends on wb.
  assign w_ready  = !rst && (&w_fits);
  assign w_accept = bus.req_valid && w_ready;

  for (genvar n = 0; n < NBANK; n++) begin : g_bank
    logic             w_hit_a, w_hit_b;
    logic [1:0]       w_need;
    logic [CNT_W-1:0] w_count, w_free;

    assign w_hit_a   = (bus.req_bank_a == BANK_W'(n));
    assign w_hit_b   = bus.req_two_op && (bus.req_bank_b == BANK_W'(n));
    assign w_need    = {1'b0, w_hit_a} + {1'b0, w_hit_b};
    assign w_fits[n] = (w_free >= CNT_W'(w_need));

    assign w_wr_en[n]  = !rst && bus.wb_en && (bus.wb_bank == BANK_W'(n));
    assign w_rd_en[n]  = !rst && !w_wr_en[n] && (w_count != '0);
    assign w_wr_row[n] = w_wr_en[n] ? bus.wb_row : '0;
    assign w_rd_row[n] = w_rd_en[n] ? w_head[n].row : '0;

    rf_bank_queue #(.QDEPTH(QDEPTH)) u_queue (
      .clk          (clk),
      .rst          (rst),
      .push0_i      (w_accept && (w_hit_a || w_hit_b)),
      .push0_data_i (w_hit_a ? w_entry_a : w_entry_b),
      .push1_i      (w_accept && w_hit_a && w_hit_b),
      .push1_data_i (w_entry_b),
      .pop_i        (w_rd_en[n]),
      .head_o       (w_head[n]),
      .count_o      (w_count),
      .free_o       (w_free)
    );
  end

  always_comb begin
    bk_vld_d   = '0;
    bk_opsel_d = '0;
    bk_ocid_d  = '{default: '0};
    for (int n = 0; n < NBANK; n++) begin
      bk_vld_d[n]   = w_rd_en[n];
      bk_opsel_d[n] = w_rd_en[n] && w_head[n].opsel;
      bk_ocid_d[n]  = w_rd_en[n] ? w_head[n].ocid : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bk_vld_q   <= '0;
      bk_opsel_q <= '0;
      bk_ocid_q  <= '{default: '0};
    end else begin
      bk_vld_q   <= bk_vld_d;
      bk_opsel_q <= bk_opsel_d;
      bk_ocid_q  <= bk_ocid_d;
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.bank_rd_en  = w_rd_en;
  assign bus.bank_rd_row = pack_rows(w_rd_row);
  assign bus.bank_wr_en  = w_wr_en;
  assign bus.bank_wr_row = pack_rows(w_wr_row);
  assign bus.bk_vld      = bk_vld_q;
  assign bus.bk_ocid     = pack_ocids(bk_ocid_q);
  assign bus.bk_opsel    = bk_opsel_q;

endmodule
`default_nettype wire
